// File: rtl/dist3_pkg.sv
// dist3 shared definitions: payload width and destination encodings.
// WORD_BITS may be overridden on the command line; defaults to 16.
// Optional feature macro: DIST3_BCAST_EN (dest 3 broadcasts instead of dropping).
`ifndef WORD_BITS
`define WORD_BITS 16
`endif

package dist3_pkg;

    localparam int unsigned NUM_SRC = 3;

    localparam logic [1:0] DEST_SRC0    = 2'd0;
    localparam logic [1:0] DEST_SRC1    = 2'd1;
    localparam logic [1:0] DEST_SRC2    = 2'd2;
    localparam logic [1:0] DEST_SPECIAL = 2'd3;

    // Output FIFOs addressed by a destination code; special selects all three.
    function automatic logic [NUM_SRC-1:0] destMask(input logic [1:0] dest);
        logic [NUM_SRC-1:0] mask;
        mask = '0;
        unique case (dest)
            DEST_SRC0:    mask = 3'b001;
            DEST_SRC1:    mask = 3'b010;
            DEST_SRC2:    mask = 3'b100;
            DEST_SPECIAL: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dist3_fifo.sv
// dist3_fifo: synchronous FIFO, p_st_bits x p_depth, async active-low reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dist3_fifo #(
    parameter int unsigned p_st_bits = 16,
    parameter int unsigned p_depth   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [p_st_bits-1:0] pushData,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [p_st_bits-1:0] head
);

    localparam int unsigned AW = (p_depth > 1) ? $clog2(p_depth) : 1;

    logic [AW:0]          wrPtrQ, rdPtrQ;
    logic [p_st_bits-1:0] memQ [p_depth];
    logic                 doPush, doPop;

    // Occupancy flags, guarded push/pop and head-of-queue read.
    always_comb begin
        empty  = (wrPtrQ == rdPtrQ);
        full   = (wrPtrQ[AW] != rdPtrQ[AW]) && (wrPtrQ[AW-1:0] == rdPtrQ[AW-1:0]);
        doPush = push & ~full;
        doPop  = pop & ~empty;
        head   = memQ[rdPtrQ[AW-1:0]];
    end

    // Storage and pointers; storage cleared on reset so an empty FIFO reads 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            memQ   <= '{default: '0};
        end else begin
            if (doPush) begin
                memQ[wrPtrQ[AW-1:0]] <= pushData;
                wrPtrQ               <= wrPtrQ + (AW+1)'(1);
            end
            if (doPop) begin
                rdPtrQ <= rdPtrQ + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/dist3.sv
// dist3: one inbound stream distributed to three independent output FIFOs by
// destination code. Dest 3 is dropped (counted in oDropCnt) unless the
// DIST3_BCAST_EN macro is defined, in which case it is written to all three.
`ifndef WORD_BITS
`define WORD_BITS 16
`endif

module dist3
    import dist3_pkg::*;
#(
    parameter int unsigned p_st_bits = `WORD_BITS,
    parameter int unsigned p_depth   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [p_st_bits-1:0] iSnk0Data,
    input  logic [1:0]           iSnk0Dest,
    input  logic                 iSnk0Valid,
    output logic                 oSnk0Ready,
    output logic [p_st_bits-1:0] oSrc0Data,
    output logic                 oSrc0Valid,
    input  logic                 iSrc0Ready,
    output logic [p_st_bits-1:0] oSrc1Data,
    output logic                 oSrc1Valid,
    input  logic                 iSrc1Ready,
    output logic [p_st_bits-1:0] oSrc2Data,
    output logic                 oSrc2Valid,
    input  logic                 iSrc2Ready,
    output logic [7:0]           oDropCnt
);

    logic [NUM_SRC-1:0]   fifoFull, fifoEmpty, fifoPush, fifoPop, srcReady, mask;
    logic [p_st_bits-1:0] fifoHead [NUM_SRC];
    logic                 accept;

    // Sink ready depends only on the fullness of the addressed FIFO(s),
    // never on same-cycle pops, so there is no ready-to-ready path.
    always_comb begin
        mask     = destMask(iSnk0Dest);
        fifoPush = '0;
`ifdef DIST3_BCAST_EN
        oSnk0Ready = ~|(fifoFull & mask);
        accept     = iSnk0Valid & oSnk0Ready;
        if (accept) fifoPush = mask;
`else
        if (iSnk0Dest == DEST_SPECIAL) begin
            oSnk0Ready = 1'b1;
        end else begin
            oSnk0Ready = ~|(fifoFull & mask);
        end
        accept = iSnk0Valid & oSnk0Ready;
        if (accept && (iSnk0Dest != DEST_SPECIAL)) fifoPush = mask;
`endif
    end

    // Output handshakes: each FIFO pops on its own valid & ready.
    always_comb begin
        srcReady = {iSrc2Ready, iSrc1Ready, iSrc0Ready};
        fifoPop  = ~fifoEmpty & srcReady;
        oSrc0Valid = ~fifoEmpty[0];
        oSrc1Valid = ~fifoEmpty[1];
        oSrc2Valid = ~fifoEmpty[2];
        oSrc0Data  = fifoHead[0];
        oSrc1Data  = fifoHead[1];
        oSrc2Data  = fifoHead[2];
    end

    for (genvar n = 0; n < NUM_SRC; n++) begin : gFifo
        dist3_fifo #(
            .p_st_bits (p_st_bits),
            .p_depth   (p_depth)
        ) uFifo (
            .clk      (clk),
            .rst      (rst),
            .push     (fifoPush[n]),
            .pushData (iSnk0Data),
            .pop      (fifoPop[n]),
            .full     (fifoFull[n]),
            .empty    (fifoEmpty[n]),
            .head     (fifoHead[n])
        );
    end

`ifdef DIST3_BCAST_EN
    assign oDropCnt = '0;
`else
    logic [7:0] dropCntQ;

    // Saturating count of discarded dest-3 beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dropCntQ <= '0;
        end else if (iSnk0Valid && (iSnk0Dest == DEST_SPECIAL) && (dropCntQ != '1)) begin
            dropCntQ <= dropCntQ + 8'(1);
        end
    end

    assign oDropCnt = dropCntQ;
`endif

endmodule

// File: tb/tb_dist3.sv
// tb_dist3: random and directed stimulus against a queue-based reference
// model of the three outputs. Honors DIST3_BCAST_EN like the design.
`ifndef WORD_BITS
`define WORD_BITS 16
`endif

module tb_dist3;

    localparam int W     = `WORD_BITS;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] iSnk0Data;
    logic [1:0]   iSnk0Dest;
    logic         iSnk0Valid;
    logic         oSnk0Ready;
    logic [W-1:0] oSrc0Data, oSrc1Data, oSrc2Data;
    logic         oSrc0Valid, oSrc1Valid, oSrc2Valid;
    logic         iSrc0Ready, iSrc1Ready, iSrc2Ready;
    logic [7:0]   oDropCnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one queue per output plus a drop counter.
    logic [W-1:0] mq [3][$];
    int           mDrop = 0;

    dist3 #(
        .p_st_bits (W),
        .p_depth   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iSnk0Data  (iSnk0Data),
        .iSnk0Dest  (iSnk0Dest),
        .iSnk0Valid (iSnk0Valid),
        .oSnk0Ready (oSnk0Ready),
        .oSrc0Data  (oSrc0Data),
        .oSrc0Valid (oSrc0Valid),
        .iSrc0Ready (iSrc0Ready),
        .oSrc1Data  (oSrc1Data),
        .oSrc1Valid (oSrc1Valid),
        .iSrc1Ready (iSrc1Ready),
        .oSrc2Data  (oSrc2Data),
        .oSrc2Valid (oSrc2Valid),
        .iSrc2Ready (iSrc2Ready),
        .oDropCnt   (oDropCnt)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] outData(input int n);
        case (n)
            0:       return oSrc0Data;
            1:       return oSrc1Data;
            default: return oSrc2Data;
        endcase
    endfunction

    function automatic logic outValid(input int n);
        case (n)
            0:       return oSrc0Valid;
            1:       return oSrc1Valid;
            default: return oSrc2Valid;
        endcase
    endfunction

    function automatic void modelClear();
        for (int n = 0; n < 3; n++) mq[n].delete();
        mDrop = 0;
    endfunction

    // Apply one cycle of stimulus away from the edge, compare all outputs
    // with the model, then advance the model and the clock together.
    task automatic step(input logic v, input logic [1:0] d, input logic [W-1:0] data,
                        input logic [2:0] rdy);
        logic expReady;
        iSnk0Valid = v;
        iSnk0Dest  = d;
        iSnk0Data  = data;
        {iSrc2Ready, iSrc1Ready, iSrc0Ready} = rdy;
        #1;
        if (d != 2'd3) begin
            expReady = (mq[d].size() < DEPTH);
        end else begin
`ifdef DIST3_BCAST_EN
            expReady = (mq[0].size() < DEPTH) && (mq[1].size() < DEPTH) &&
                       (mq[2].size() < DEPTH);
`else
            expReady = 1'b1;
`endif
        end
        checkEq("sinkReady", 32'(oSnk0Ready), 32'(expReady));
        for (int n = 0; n < 3; n++) begin
            checkEq($sformatf("src%0dValid", n), 32'(outValid(n)), 32'(mq[n].size() != 0));
            if (mq[n].size() != 0)
                checkEq($sformatf("src%0dData", n), 32'(outData(n)), 32'(mq[n][0]));
        end
        checkEq("dropCnt", 32'(oDropCnt), 32'(mDrop));
        for (int n = 0; n < 3; n++)
            if (mq[n].size() != 0 && rdy[n]) void'(mq[n].pop_front());
        if (v && expReady) begin
            if (d != 2'd3) begin
                mq[d].push_back(data);
            end else begin
`ifdef DIST3_BCAST_EN
                for (int n = 0; n < 3; n++) mq[n].push_back(data);
`else
                if (mDrop < 255) mDrop++;
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        iSnk0Valid = 1'b0;
        iSnk0Dest  = 2'd0;
        iSnk0Data  = '0;
        {iSrc2Ready, iSrc1Ready, iSrc0Ready} = 3'b111;
        #2;
        checkEq("rstValid", 32'({oSrc2Valid, oSrc1Valid, oSrc0Valid}), 32'd0);
        checkEq("rstData0", 32'(oSrc0Data), 32'd0);
        checkEq("rstDrop", 32'(oDropCnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single beat to dest 1 appears one cycle later on Src1 only.
        step(1'b1, 2'd1, W'('h1234), 3'b111);
        checkEq("d1Valid", 32'({oSrc2Valid, oSrc1Valid, oSrc0Valid}), 32'b010);
        checkEq("d1Data", 32'(oSrc1Data), 32'h1234);
        step(1'b0, 2'd0, '0, 3'b111);

        // Src0 stalled: A,B fill it, C refused; then drains in order.
        step(1'b1, 2'd0, W'('hA), 3'b110);
        step(1'b1, 2'd0, W'('hB), 3'b110);
        iSnk0Valid = 1'b1;
        iSnk0Dest  = 2'd0;
        #1;
        checkEq("fullReady", 32'(oSnk0Ready), 32'd0);
        checkEq("headA", 32'(oSrc0Data), 32'hA);
        // Pop in same cycle still refuses push into a full FIFO.
        step(1'b1, 2'd0, W'('hC), 3'b111);
        checkEq("headB", 32'(oSrc0Data), 32'hB);
        step(1'b1, 2'd0, W'('hC), 3'b110);
        checkEq("headBHeld", 32'(oSrc0Data), 32'hB);
        step(1'b0, 2'd0, '0, 3'b111);
        checkEq("headC", 32'(oSrc0Data), 32'hC);
        step(1'b0, 2'd0, '0, 3'b111);

        // Src2 stalled and full does not block dest 0.
        step(1'b1, 2'd2, W'('h21), 3'b011);
        step(1'b1, 2'd2, W'('h22), 3'b011);
        step(1'b1, 2'd0, W'('h55), 3'b011);
        checkEq("s0Delivered", 32'(oSrc0Data), 32'h55);
        checkEq("s2Held", 32'(oSrc2Data), 32'h21);
        repeat (3) step(1'b0, 2'd0, '0, 3'b111);

        // Special destination, 300 beats.
`ifdef DIST3_BCAST_EN
        step(1'b1, 2'd3, W'('hAA), 3'b000);
        checkEq("bcastValid", 32'({oSrc2Valid, oSrc1Valid, oSrc0Valid}), 32'b111);
        checkEq("bcastData", 32'({oSrc0Data == W'('hAA), oSrc1Data == W'('hAA),
                                  oSrc2Data == W'('hAA)}), 32'b111);
        for (int i = 0; i < 299; i++) step(1'b1, 2'd3, W'('hAA), 3'b111);
        step(1'b0, 2'd0, '0, 3'b111);
        checkEq("bcastDrop", 32'(oDropCnt), 32'd0);
`else
        for (int i = 0; i < 300; i++) step(1'b1, 2'd3, W'($urandom), 3'b111);
        checkEq("dropSat", 32'(oDropCnt), 32'd255);
        checkEq("dropNoValid", 32'({oSrc2Valid, oSrc1Valid, oSrc0Valid}), 32'd0);
`endif

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] d;
            d = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            step($urandom_range(0, 3) != 0, d, W'($urandom),
                 3'($urandom) | 3'($urandom));
        end

        // Reset with data buffered.
        step(1'b1, 2'd1, W'('h77), 3'b000);
        step(1'b1, 2'd2, W'('h78), 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkEq("midRstValid", 32'({oSrc2Valid, oSrc1Valid, oSrc0Valid}), 32'd0);
        checkEq("midRstData", 32'({oSrc0Data, oSrc1Data, oSrc2Data} == '0), 32'd1);
        checkEq("midRstDrop", 32'(oDropCnt), 32'd0);
        modelClear();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 2'd2, W'('h99), 3'b111);
        checkEq("postRstValid", 32'({oSrc2Valid, oSrc1Valid, oSrc0Valid}), 32'b100);
        checkEq("postRstData", 32'(oSrc2Data), 32'h99);
        step(1'b0, 2'd0, '0, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
